// File: rtl/lc3_regfile_pkg.sv
// Shared types and constants for the LC-3 register-file write port.
//   word_t      : one register / bus word
//   reg_idx_t   : 3-bit register index (R0..R7)
//   rf_state_e  : clear-engine FSM states
//   LINK_REG    : destination chosen when DRMUX=1 (JSR/JSRR/TRAP)
//   CC_RESET    : {N,Z,P} value after reset or clear (Z set)
package lc3_regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [2:0]        reg_idx_t;

    localparam reg_idx_t   LINK_REG  = 3'd7;
    localparam word_t      CLEAR_VAL = 16'h0000;
    localparam logic [2:0] CC_RESET  = 3'b010;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_write_port_cc_gen.sv
// cc_gen: combinational condition-code generator.
//   data : word to classify
//   nzp  : {N,Z,P}, exactly one bit set
module cc_gen
    import lc3_regfile_pkg::*;
(
    input  word_t      data,
    output logic [2:0] nzp
);

    logic is_zero;

    assign is_zero = (data == '0);
    assign nzp     = {data[DATA_W-1], is_zero, ~data[DATA_W-1] & ~is_zero};

endmodule

// File: rtl/reg_file_write_port.sv
// reg_file_write_port: write side of the LC-3 register file (R0..R7),
// NZP condition-code register and an 8-cycle sequenced clear engine.
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   LD_REG, DRMUX     : write enable, destination select (0 = IR_DR, 1 = R7)
//   IR_DR, BUS        : IR[11:9] destination, write data / CC source
//   LD_CC             : condition-code load enable
//   clear_req         : one-cycle pulse starting the clear sequence
//   reg0_out..reg7_out: registered register contents
//   N, Z, P           : registered condition codes
//   busy              : high while the clear sequence runs (8 cycles)
//   wr_dropped        : one-cycle pulse when LD_REG/LD_CC arrived while busy
//   state_dbg         : current FSM state, for observation only
//
// Handshake: there is no back-pressure. A write or CC load is accepted at a
// rising edge only when busy=0; otherwise it is discarded and wr_dropped
// pulses in the following cycle (one pulse per cycle, however many enables).
module reg_file_write_port
    import lc3_regfile_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset_n,
    input  logic      LD_REG,
    input  logic      DRMUX,
    input  reg_idx_t  IR_DR,
    input  word_t     BUS,
    input  logic      LD_CC,
    input  logic      clear_req,
    output word_t     reg0_out,
    output word_t     reg1_out,
    output word_t     reg2_out,
    output word_t     reg3_out,
    output word_t     reg4_out,
    output word_t     reg5_out,
    output word_t     reg6_out,
    output word_t     reg7_out,
    output logic      N,
    output logic      Z,
    output logic      P,
    output logic      busy,
    output logic      wr_dropped,
    output rf_state_e state_dbg
);

    word_t      regs [NUM_REGS];
    logic [2:0] cc_q;
    rf_state_e  state, state_next;
    reg_idx_t   idx, idx_next;

    logic       reg_we;
    reg_idx_t   reg_waddr;
    word_t      reg_wdata;
    logic       cc_we;
    word_t      cc_src;
    logic [2:0] cc_next;

    assign busy = (state == CLEAR);

    // The clear path reuses the generator with a constant zero word, which
    // yields the reset pattern Z=1 on the final clear step.
    assign cc_src = busy ? CLEAR_VAL : BUS;

    cc_gen u_cc_gen (
        .data (cc_src),
        .nzp  (cc_next)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        reg_we     = 1'b0;
        reg_waddr  = DRMUX ? LINK_REG : IR_DR;
        reg_wdata  = BUS;
        cc_we      = 1'b0;
        case (state)
            IDLE: begin
                // A write in the same cycle as clear_req still lands; the
                // clear sequence then overwrites it.
                reg_we = LD_REG;
                cc_we  = LD_CC;
                if (clear_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                reg_we    = 1'b1;
                reg_waddr = idx;
                reg_wdata = CLEAR_VAL;
                idx_next  = reg_idx_t'(idx + 3'd1);
                if (idx == reg_idx_t'(NUM_REGS - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cc_we      = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            cc_q       <= CC_RESET;
            state      <= IDLE;
            idx        <= '0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            wr_dropped <= busy & (LD_REG | LD_CC);
            if (reg_we) begin
                regs[reg_waddr] <= reg_wdata;
            end
            if (cc_we) begin
                cc_q <= cc_next;
            end
        end
    end

    assign reg0_out  = regs[0];
    assign reg1_out  = regs[1];
    assign reg2_out  = regs[2];
    assign reg3_out  = regs[3];
    assign reg4_out  = regs[4];
    assign reg5_out  = regs[5];
    assign reg6_out  = regs[6];
    assign reg7_out  = regs[7];
    assign {N, Z, P} = cc_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_reg_file_write_port.sv
module tb_reg_file_write_port;
  import lc3_regfile_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        LD_REG = 1'b0;
  logic        DRMUX = 1'b0;
  logic [2:0]  IR_DR = 3'd0;
  logic [15:0] BUS = 16'h0000;
  logic        LD_CC = 1'b0;
  logic        clear_req = 1'b0;
  logic [15:0] reg0_out, reg1_out, reg2_out, reg3_out;
  logic [15:0] reg4_out, reg5_out, reg6_out, reg7_out;
  logic        N, Z, P, busy, wr_dropped;
  rf_state_e   state_dbg;

  reg_file_write_port dut (
    .Clk(Clk), .Reset_n(Reset_n), .LD_REG(LD_REG), .DRMUX(DRMUX),
    .IR_DR(IR_DR), .BUS(BUS), .LD_CC(LD_CC), .clear_req(clear_req),
    .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
    .reg3_out(reg3_out), .reg4_out(reg4_out), .reg5_out(reg5_out),
    .reg6_out(reg6_out), .reg7_out(reg7_out),
    .N(N), .Z(Z), .P(P), .busy(busy), .wr_dropped(wr_dropped),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_regs [8];
  logic [2:0]  model_cc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] get_reg(input int i);
    case (i)
      0: return reg0_out;
      1: return reg1_out;
      2: return reg2_out;
      3: return reg3_out;
      4: return reg4_out;
      5: return reg5_out;
      6: return reg6_out;
      default: return reg7_out;
    endcase
  endfunction

  function automatic logic [2:0] exp_cc(input logic [15:0] d);
    return {d[15], d == 16'h0000, ~d[15] & (d != 16'h0000)};
  endfunction

  function automatic logic [15:0] nzp();
    return {13'd0, N, Z, P};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    model_cc = 3'b010;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_r%0d", tag, i), get_reg(i), model_regs[i]);
    end
    check({tag, "_nzp"}, nzp(), {13'd0, model_cc});
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    LD_REG = 1'b0; LD_CC = 1'b0; clear_req = 1'b0; DRMUX = 1'b0;
  endtask

  // One IDLE-state write/CC-load cycle; expected register value queued at drive time.
  task automatic write_op(input string tag, input logic ld_reg, input logic drmux,
                          input logic [2:0] ir_dr, input logic [15:0] data,
                          input logic ld_cc);
    logic [2:0] dr;
    @(negedge Clk);
    LD_REG = ld_reg; DRMUX = drmux; IR_DR = ir_dr; BUS = data; LD_CC = ld_cc;
    dr = drmux ? 3'd7 : ir_dr;
    if (ld_reg) begin
      model_regs[dr] = data;
      exp_q.push_back(data);
    end
    if (ld_cc) model_cc = exp_cc(data);
    @(posedge Clk); #1;
    idle_inputs();
    if (ld_reg) check({tag, "_wr"}, get_reg(int'(dr)), exp_q.pop_front());
    check({tag, "_nzp"}, nzp(), {13'd0, model_cc});
    check({tag, "_drop"}, {15'd0, wr_dropped}, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       ld_any;
    logic [2:0] cc_before;
    model_reset();

    // Reset state
    #12;
    check("rst_state", {15'd0, state_dbg}, {15'd0, IDLE});
    check("rst_drop", {15'd0, wr_dropped}, 16'd0);
    check_all("rst");
    @(negedge Clk); Reset_n = 1'b1;

    // Directed writes
    write_op("w_r3", 1'b1, 1'b0, 3'd3, 16'hBEEF, 1'b0);
    check_all("after_r3");
    write_op("w_link", 1'b1, 1'b1, 3'd2, 16'h3001, 1'b0);
    check_all("after_link");
    write_op("w_r7dir", 1'b1, 1'b0, 3'd7, 16'h3002, 1'b0);
    check_all("after_r7dir");

    // Condition codes
    write_op("cc_8000", 1'b0, 1'b0, 3'd0, 16'h8000, 1'b1);
    write_op("cc_0000", 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
    write_op("cc_0001", 1'b0, 1'b0, 3'd0, 16'h0001, 1'b1);
    write_op("cc_7fff", 1'b0, 1'b0, 3'd0, 16'h7FFF, 1'b1);
    write_op("cc_ffff", 1'b0, 1'b0, 3'd0, 16'hFFFF, 1'b1);
    write_op("both", 1'b1, 1'b0, 3'd6, 16'h0000, 1'b1);

    // Random writes
    for (int i = 0; i < 20; i++) begin
      write_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)));
    end
    check_all("after_rnd");

    // Preload FFFF everywhere, leave NZP = 001
    for (int i = 0; i < 8; i++) write_op("pre", 1'b1, 1'b0, 3'(i), 16'hFFFF, 1'b0);
    write_op("pre_cc", 1'b0, 1'b0, 3'd0, 16'h0001, 1'b1);
    check_all("preloaded");

    // Clear with a coincident write to R4 (write lands, clear erases it)
    @(negedge Clk);
    clear_req = 1'b1; LD_REG = 1'b1; IR_DR = 3'd4; BUS = 16'hAAAA;
    model_regs[4] = 16'hAAAA;
    @(posedge Clk); #1;
    idle_inputs();
    check("clr_start_busy", {15'd0, busy}, 16'd1);
    check("clr_start_state", {15'd0, state_dbg}, {15'd0, CLEAR});
    check("clr_same_cycle_wr", reg4_out, 16'hAAAA);
    cc_before = model_cc;

    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      ld_any = 1'b0;
      if (k == 2) begin LD_REG = 1'b1; IR_DR = 3'd1; BUS = 16'h1234; ld_any = 1'b1; end
      if (k == 3) begin LD_REG = 1'b1; IR_DR = 3'd5; BUS = 16'h1234; ld_any = 1'b1; end
      if (k == 4) begin LD_CC = 1'b1; BUS = 16'h8000; ld_any = 1'b1; end
      if (k == 5) clear_req = 1'b1;
      if (k == 6) begin LD_REG = 1'b1; LD_CC = 1'b1; IR_DR = 3'd0; BUS = 16'h8000; ld_any = 1'b1; end
      model_regs[k] = 16'h0000;
      exp_q.push_back(16'h0000);
      @(posedge Clk); #1;
      idle_inputs();
      check($sformatf("clr_r%0d", k), get_reg(k), exp_q.pop_front());
      if (k < 7) check($sformatf("clr_r%0d_untouched", k + 1), get_reg(k + 1), model_regs[k + 1]);
      check($sformatf("clr_busy_%0d", k), {15'd0, busy}, {15'd0, k < 7});
      check($sformatf("clr_drop_%0d", k), {15'd0, wr_dropped}, {15'd0, ld_any});
      check($sformatf("clr_nzp_%0d", k), nzp(), (k == 7) ? 16'd2 : {13'd0, cc_before});
    end
    model_cc = 3'b010;
    @(posedge Clk); #1;
    check("clr_not_extended", {15'd0, busy}, 16'd0);
    check("clr_end_state", {15'd0, state_dbg}, {15'd0, IDLE});
    check_all("after_clear");

    // Reset in the middle of a clear
    write_op("pre6", 1'b1, 1'b0, 3'd6, 16'h5555, 1'b0);
    write_op("pre_cc2", 1'b0, 1'b0, 3'd0, 16'h8000, 1'b1);
    @(negedge Clk); clear_req = 1'b1;
    @(posedge Clk); #1; idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
    end
    check("mid_busy_before_rst", {15'd0, busy}, 16'd1);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_state", {15'd0, state_dbg}, {15'd0, IDLE});
    check("mid_rst_drop", {15'd0, wr_dropped}, 16'd0);
    check_all("mid_rst");
    @(negedge Clk); Reset_n = 1'b1;
    write_op("post_rst_r1", 1'b1, 1'b0, 3'd1, 16'h1111, 1'b0);
    check_all("post_rst");

    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL exp_q_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
